// File: rtl/pcie_crdt_up_tracker.sv
// UP-direction (CC+RQ) flow-control credit tracker: accumulates hard-IP credit
// advertisements, detects infinite credits at init, and grants/debits TLPs.
module pcie_crdt_up_tracker #(
    parameter int UPD_HDR_W  = 2,
    parameter int UPD_DATA_W = 4,
    parameter int HDR_CNT_W  = 12,
    parameter int DATA_CNT_W = 16,
    parameter int REQ_DATA_W = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  crdt_up_init_done,
    input  logic [5:0]            crdt_up_update,
    input  logic [UPD_HDR_W-1:0]  crdt_up_cnt_ph,
    input  logic [UPD_HDR_W-1:0]  crdt_up_cnt_nph,
    input  logic [UPD_HDR_W-1:0]  crdt_up_cnt_cplh,
    input  logic [UPD_DATA_W-1:0] crdt_up_cnt_pd,
    input  logic [UPD_DATA_W-1:0] crdt_up_cnt_npd,
    input  logic [UPD_DATA_W-1:0] crdt_up_cnt_cpld,
    input  logic                  req_vld,
    input  logic [1:0]            req_type,
    input  logic [REQ_DATA_W-1:0] req_data_crdt,
    output logic                  req_rdy,
    output logic [5:0]            infinite,
    output logic                  err_ovf
);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                state_r;
    logic [HDR_CNT_W-1:0]  hdr_cnt_r  [3];
    logic [DATA_CNT_W-1:0] data_cnt_r [3];
    logic [5:0]            infinite_r;
    logic                  err_ovf_r;

    logic [HDR_CNT_W-1:0]  hdr_fld_s  [3];
    logic [DATA_CNT_W-1:0] data_fld_s [3];
    logic [HDR_CNT_W:0]    hdr_sum_s  [3];
    logic [DATA_CNT_W:0]   data_sum_s [3];
    logic [HDR_CNT_W-1:0]  hdr_nxt_s  [3];
    logic [DATA_CNT_W-1:0] data_nxt_s [3];
    logic [2:0]            hdr_vld_s;
    logic [2:0]            data_vld_s;
    logic [2:0]            hdr_inf_s;
    logic [2:0]            data_inf_s;
    logic [2:0]            hdr_zero_s;
    logic [2:0]            data_zero_s;
    logic [2:0]            take_s;
    logic [DATA_CNT_W-1:0] req_ext_s;
    logic                  hdr_ok_s;
    logic                  data_ok_s;
    logic                  rdy_s;
    logic                  grant_s;
    logic                  ovf_s;

    // Re-index per-type fields as P=0, NP=1, CPL=2.
    always_comb begin
        hdr_fld_s[0]  = {{(HDR_CNT_W-UPD_HDR_W){1'b0}}, crdt_up_cnt_ph};
        hdr_fld_s[1]  = {{(HDR_CNT_W-UPD_HDR_W){1'b0}}, crdt_up_cnt_nph};
        hdr_fld_s[2]  = {{(HDR_CNT_W-UPD_HDR_W){1'b0}}, crdt_up_cnt_cplh};
        data_fld_s[0] = {{(DATA_CNT_W-UPD_DATA_W){1'b0}}, crdt_up_cnt_pd};
        data_fld_s[1] = {{(DATA_CNT_W-UPD_DATA_W){1'b0}}, crdt_up_cnt_npd};
        data_fld_s[2] = {{(DATA_CNT_W-UPD_DATA_W){1'b0}}, crdt_up_cnt_cpld};
        hdr_vld_s     = {crdt_up_update[3], crdt_up_update[4], crdt_up_update[5]};
        data_vld_s    = {crdt_up_update[0], crdt_up_update[1], crdt_up_update[2]};
        hdr_inf_s     = {infinite_r[3], infinite_r[4], infinite_r[5]};
        data_inf_s    = {infinite_r[0], infinite_r[1], infinite_r[2]};
        req_ext_s     = {{(DATA_CNT_W-REQ_DATA_W){1'b0}}, req_data_crdt};
    end

    // Grant decision from registered counters; link-down suppresses it immediately.
    always_comb begin
        hdr_ok_s  = 1'b0;
        data_ok_s = 1'b0;
        case (req_type)
            2'd0: begin
                hdr_ok_s  = hdr_inf_s[0] | (hdr_cnt_r[0] != {HDR_CNT_W{1'b0}});
                data_ok_s = data_inf_s[0] | (data_cnt_r[0] >= req_ext_s);
            end
            2'd1: begin
                hdr_ok_s  = hdr_inf_s[1] | (hdr_cnt_r[1] != {HDR_CNT_W{1'b0}});
                data_ok_s = data_inf_s[1] | (data_cnt_r[1] >= req_ext_s);
            end
            2'd2: begin
                hdr_ok_s  = hdr_inf_s[2] | (hdr_cnt_r[2] != {HDR_CNT_W{1'b0}});
                data_ok_s = data_inf_s[2] | (data_cnt_r[2] >= req_ext_s);
            end
            default: begin
                hdr_ok_s  = 1'b0;
                data_ok_s = 1'b0;
            end
        endcase
        rdy_s   = (state_r == ST_RUN) & crdt_up_init_done & hdr_ok_s & data_ok_s;
        grant_s = req_vld & rdy_s;
        take_s  = {grant_s & (req_type == 2'd2),
                   grant_s & (req_type == 2'd1),
                   grant_s & (req_type == 2'd0)};
    end

    // Net credit update per counter: add advertisement, subtract grant, saturate at all-ones.
    always_comb begin
        ovf_s = 1'b0;
        for (int t = 0; t < 3; t++) begin
            hdr_sum_s[t] = {1'b0, hdr_cnt_r[t]}
                         + {1'b0, (hdr_vld_s[t] ? hdr_fld_s[t] : {HDR_CNT_W{1'b0}})}
                         - {{HDR_CNT_W{1'b0}}, take_s[t]};
            data_sum_s[t] = {1'b0, data_cnt_r[t]}
                          + {1'b0, (data_vld_s[t] ? data_fld_s[t] : {DATA_CNT_W{1'b0}})}
                          - {1'b0, (take_s[t] ? req_ext_s : {DATA_CNT_W{1'b0}})};
            if (hdr_inf_s[t]) begin
                hdr_nxt_s[t] = {HDR_CNT_W{1'b0}};
            end else if (hdr_sum_s[t][HDR_CNT_W]) begin
                hdr_nxt_s[t] = {HDR_CNT_W{1'b1}};
                ovf_s        = 1'b1;
            end else begin
                hdr_nxt_s[t] = hdr_sum_s[t][HDR_CNT_W-1:0];
            end
            if (data_inf_s[t]) begin
                data_nxt_s[t] = {DATA_CNT_W{1'b0}};
            end else if (data_sum_s[t][DATA_CNT_W]) begin
                data_nxt_s[t] = {DATA_CNT_W{1'b1}};
                ovf_s         = 1'b1;
            end else begin
                data_nxt_s[t] = data_sum_s[t][DATA_CNT_W-1:0];
            end
            hdr_zero_s[t]  = (hdr_nxt_s[t] == {HDR_CNT_W{1'b0}});
            data_zero_s[t] = (data_nxt_s[t] == {DATA_CNT_W{1'b0}});
        end
    end

    // Init/run state, counters, infinite flags and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_INIT;
            infinite_r <= 6'b000000;
            err_ovf_r  <= 1'b0;
            for (int t = 0; t < 3; t++) begin
                hdr_cnt_r[t]  <= {HDR_CNT_W{1'b0}};
                data_cnt_r[t] <= {DATA_CNT_W{1'b0}};
            end
        end else begin
            case (state_r)
                ST_INIT: begin
                    err_ovf_r <= err_ovf_r | ovf_s;
                    for (int t = 0; t < 3; t++) begin
                        hdr_cnt_r[t]  <= hdr_nxt_s[t];
                        data_cnt_r[t] <= data_nxt_s[t];
                    end
                    if (crdt_up_init_done) begin
                        state_r    <= ST_RUN;
                        infinite_r <= {hdr_zero_s[0], hdr_zero_s[1], hdr_zero_s[2],
                                       data_zero_s[0], data_zero_s[1], data_zero_s[2]};
                    end else begin
                        state_r    <= ST_INIT;
                        infinite_r <= 6'b000000;
                    end
                end
                ST_RUN: begin
                    if (!crdt_up_init_done) begin
                        state_r    <= ST_INIT;
                        infinite_r <= 6'b000000;
                        for (int t = 0; t < 3; t++) begin
                            hdr_cnt_r[t]  <= {HDR_CNT_W{1'b0}};
                            data_cnt_r[t] <= {DATA_CNT_W{1'b0}};
                        end
                    end else begin
                        state_r   <= ST_RUN;
                        err_ovf_r <= err_ovf_r | ovf_s;
                        for (int t = 0; t < 3; t++) begin
                            hdr_cnt_r[t]  <= hdr_nxt_s[t];
                            data_cnt_r[t] <= data_nxt_s[t];
                        end
                    end
                end
                default: begin
                    state_r <= ST_INIT;
                end
            endcase
        end
    end

    assign req_rdy  = rdy_s;
    assign infinite = infinite_r;
    assign err_ovf  = err_ovf_r;

endmodule

// File: tb/tb_pcie_crdt_up_tracker.sv
// Directed bench for pcie_crdt_up_tracker: credits are observed through
// REQ_RDY probes (REQ_VLD=0 never debits), grants through REQ_VLD=1 offers.
module tb_pcie_crdt_up_tracker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       crdt_up_init_done;
    logic [5:0] crdt_up_update;
    logic [1:0] crdt_up_cnt_ph, crdt_up_cnt_nph, crdt_up_cnt_cplh;
    logic [3:0] crdt_up_cnt_pd, crdt_up_cnt_npd, crdt_up_cnt_cpld;
    logic       req_vld;
    logic [1:0] req_type;
    logic [9:0] req_data_crdt;
    logic       req_rdy;
    logic [5:0] infinite;
    logic       err_ovf;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    pcie_crdt_up_tracker dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .crdt_up_init_done (crdt_up_init_done),
        .crdt_up_update    (crdt_up_update),
        .crdt_up_cnt_ph    (crdt_up_cnt_ph),
        .crdt_up_cnt_nph   (crdt_up_cnt_nph),
        .crdt_up_cnt_cplh  (crdt_up_cnt_cplh),
        .crdt_up_cnt_pd    (crdt_up_cnt_pd),
        .crdt_up_cnt_npd   (crdt_up_cnt_npd),
        .crdt_up_cnt_cpld  (crdt_up_cnt_cpld),
        .req_vld           (req_vld),
        .req_type          (req_type),
        .req_data_crdt     (req_data_crdt),
        .req_rdy           (req_rdy),
        .infinite          (infinite),
        .err_ovf           (err_ovf)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_upd();
        crdt_up_update   = 6'b000000;
        crdt_up_cnt_ph   = 2'd0;
        crdt_up_cnt_nph  = 2'd0;
        crdt_up_cnt_cplh = 2'd0;
        crdt_up_cnt_pd   = 4'd0;
        crdt_up_cnt_npd  = 4'd0;
        crdt_up_cnt_cpld = 4'd0;
    endtask

    task automatic probe(input logic [1:0] t, input logic [9:0] c, output logic r);
        req_vld       = 1'b0;
        req_type      = t;
        req_data_crdt = c;
        #1;
        r = req_rdy;
    endtask

    task automatic offer(input logic [1:0] t, input logic [9:0] c, output logic r);
        req_vld       = 1'b1;
        req_type      = t;
        req_data_crdt = c;
        #1;
        r = req_rdy;
    endtask

    task automatic link_down();
        req_vld           = 1'b0;
        crdt_up_init_done = 1'b0;
        step();
    endtask

    // Load credits during INIT in field-sized chunks, then raise INIT_DONE.
    task automatic set_credits(input int ph, input int nph, input int cplh,
                               input int pd, input int npd, input int cpld);
        int rem [6];
        int amt;
        rem = '{ph, nph, cplh, pd, npd, cpld};
        while (rem[0] + rem[1] + rem[2] + rem[3] + rem[4] + rem[5] > 0) begin
            clr_upd();
            for (int i = 0; i < 6; i++) begin
                if (rem[i] > 0) begin
                    amt = (i < 3) ? ((rem[i] > 3) ? 3 : rem[i]) : ((rem[i] > 15) ? 15 : rem[i]);
                    rem[i] -= amt;
                    crdt_up_update[5-i] = 1'b1;
                    case (i)
                        0: crdt_up_cnt_ph   = 2'(amt);
                        1: crdt_up_cnt_nph  = 2'(amt);
                        2: crdt_up_cnt_cplh = 2'(amt);
                        3: crdt_up_cnt_pd   = 4'(amt);
                        4: crdt_up_cnt_npd  = 4'(amt);
                        default: crdt_up_cnt_cpld = 4'(amt);
                    endcase
                end
            end
            step();
        end
        clr_upd();
        crdt_up_init_done = 1'b1;
        step();
    endtask

    task automatic test_reset();
        logic r;
        offer(2'd0, 10'd0, r);
        if (r !== 1'b0) begin $display("FAIL reset_rdy: got %b want 0", r); nerr++; end
        nvec++;
        if (infinite !== 6'b000000) begin $display("FAIL reset_inf: got %b want 000000", infinite); nerr++; end
        nvec++;
        if (err_ovf !== 1'b0) begin $display("FAIL reset_ovf: got %b want 0", err_ovf); nerr++; end
        nvec++;
        rst_n = 1'b1;
        step();
        offer(2'd0, 10'd0, r);
        if (r !== 1'b0) begin $display("FAIL init_rdy: got %b want 0", r); nerr++; end
        nvec++;
        req_vld = 1'b0;
    endtask

    task automatic test_init();
        logic r;
        crdt_up_update = 6'b111111;
        crdt_up_cnt_ph = 2'd3; crdt_up_cnt_nph = 2'd1; crdt_up_cnt_cplh = 2'd1;
        crdt_up_cnt_pd = 4'd8; crdt_up_cnt_npd = 4'd1; crdt_up_cnt_cpld = 4'd1;
        step();
        clr_upd();
        crdt_up_update = 6'b100100;
        crdt_up_cnt_ph = 2'd3; crdt_up_cnt_pd = 4'd8;
        step();
        clr_upd();
        crdt_up_update    = 6'b100000;
        crdt_up_cnt_ph    = 2'd2;
        crdt_up_init_done = 1'b1;
        step();
        clr_upd();
        if (infinite !== 6'b000000) begin $display("FAIL init_inf: got %b want 000000", infinite); nerr++; end
        nvec++;
        probe(2'd0, 10'd16, r);
        if (r !== 1'b1) begin $display("FAIL init_pd16: got %b want 1", r); nerr++; end
        nvec++;
        probe(2'd0, 10'd17, r);
        if (r !== 1'b0) begin $display("FAIL init_pd17: got %b want 0", r); nerr++; end
        nvec++;
        probe(2'd3, 10'd0, r);
        if (r !== 1'b0) begin $display("FAIL reserved_type: got %b want 0", r); nerr++; end
        nvec++;
        probe(2'd1, 10'd1, r);
        if (r !== 1'b1) begin $display("FAIL init_np1: got %b want 1", r); nerr++; end
        nvec++;
        offer(2'd0, 10'd3, r);
        if (r !== 1'b1) begin $display("FAIL grant_p3: got %b want 1", r); nerr++; end
        nvec++;
        step();
        probe(2'd0, 10'd13, r);
        if (r !== 1'b1) begin $display("FAIL after_pd13: got %b want 1", r); nerr++; end
        nvec++;
        probe(2'd0, 10'd14, r);
        if (r !== 1'b0) begin $display("FAIL after_pd14: got %b want 0", r); nerr++; end
        nvec++;
        for (int i = 0; i < 7; i++) begin
            offer(2'd0, 10'd0, r);
            if (r !== 1'b1) begin $display("FAIL drain_ph%0d: got %b want 1", i, r); nerr++; end
            nvec++;
            step();
        end
        probe(2'd0, 10'd0, r);
        if (r !== 1'b0) begin $display("FAIL ph_empty: got %b want 0", r); nerr++; end
        nvec++;
    endtask

    task automatic test_infinite();
        logic r;
        int   grants = 0;
        link_down();
        set_credits(2, 1, 0, 2, 1, 0);
        if (infinite !== 6'b001001) begin $display("FAIL inf_flags: got %b want 001001", infinite); nerr++; end
        nvec++;
        for (int i = 0; i < 100; i++) begin
            offer(2'd2, 10'd64, r);
            if (r === 1'b1) grants++;
            step();
        end
        req_vld = 1'b0;
        if (grants !== 100) begin $display("FAIL inf_grants: got %0d want 100", grants); nerr++; end
        nvec++;
        crdt_up_update = 6'b001001;
        crdt_up_cnt_cplh = 2'd3; crdt_up_cnt_cpld = 4'd15;
        step();
        clr_upd();
        if (infinite !== 6'b001001) begin $display("FAIL inf_keep: got %b want 001001", infinite); nerr++; end
        nvec++;
        probe(2'd0, 10'd2, r);
        if (r !== 1'b1) begin $display("FAIL inf_p_ok: got %b want 1", r); nerr++; end
        nvec++;
        probe(2'd0, 10'd3, r);
        if (r !== 1'b0) begin $display("FAIL inf_p_lim: got %b want 0", r); nerr++; end
        nvec++;
    endtask

    task automatic test_exhaustion();
        logic r;
        link_down();
        set_credits(1, 1, 1, 8, 1, 1);
        offer(2'd0, 10'd4, r);
        if (r !== 1'b1) begin $display("FAIL exh_first: got %b want 1", r); nerr++; end
        nvec++;
        step();
        for (int i = 0; i < 3; i++) begin
            offer(2'd0, 10'd4, r);
            if (r !== 1'b0) begin $display("FAIL exh_stall%0d: got %b want 0", i, r); nerr++; end
            nvec++;
            step();
        end
        crdt_up_update = 6'b100000;
        crdt_up_cnt_ph = 2'd1;
        offer(2'd0, 10'd4, r);
        if (r !== 1'b0) begin $display("FAIL exh_updcyc: got %b want 0", r); nerr++; end
        nvec++;
        step();
        clr_upd();
        offer(2'd0, 10'd4, r);
        if (r !== 1'b1) begin $display("FAIL exh_second: got %b want 1", r); nerr++; end
        nvec++;
        step();
        probe(2'd0, 10'd0, r);
        if (r !== 1'b0) begin $display("FAIL exh_after: got %b want 0", r); nerr++; end
        nvec++;
    endtask

    task automatic test_data_limited();
        logic r;
        link_down();
        set_credits(1, 5, 1, 1, 2, 1);
        offer(2'd1, 10'd3, r);
        if (r !== 1'b0) begin $display("FAIL dl_stall: got %b want 0", r); nerr++; end
        nvec++;
        step();
        crdt_up_update  = 6'b000010;
        crdt_up_cnt_npd = 4'd1;
        offer(2'd1, 10'd3, r);
        if (r !== 1'b0) begin $display("FAIL dl_updcyc: got %b want 0", r); nerr++; end
        nvec++;
        step();
        clr_upd();
        offer(2'd1, 10'd3, r);
        if (r !== 1'b1) begin $display("FAIL dl_grant: got %b want 1", r); nerr++; end
        nvec++;
        step();
        probe(2'd1, 10'd1, r);
        if (r !== 1'b0) begin $display("FAIL dl_npd0: got %b want 0", r); nerr++; end
        nvec++;
        for (int i = 0; i < 4; i++) begin
            offer(2'd1, 10'd0, r);
            if (r !== 1'b1) begin $display("FAIL dl_nph%0d: got %b want 1", i, r); nerr++; end
            nvec++;
            step();
        end
        probe(2'd1, 10'd0, r);
        if (r !== 1'b0) begin $display("FAIL dl_nph_empty: got %b want 0", r); nerr++; end
        nvec++;
    endtask

    task automatic test_simultaneous();
        logic r;
        link_down();
        set_credits(2, 1, 1, 5, 1, 1);
        crdt_up_update = 6'b000100;
        crdt_up_cnt_pd = 4'd4;
        offer(2'd0, 10'd5, r);
        if (r !== 1'b1) begin $display("FAIL sim_grant: got %b want 1", r); nerr++; end
        nvec++;
        step();
        clr_upd();
        probe(2'd0, 10'd4, r);
        if (r !== 1'b1) begin $display("FAIL sim_pd4: got %b want 1", r); nerr++; end
        nvec++;
        probe(2'd0, 10'd5, r);
        if (r !== 1'b0) begin $display("FAIL sim_pd5: got %b want 0", r); nerr++; end
        nvec++;
        if (err_ovf !== 1'b0) begin $display("FAIL sim_ovf: got %b want 0", err_ovf); nerr++; end
        nvec++;
    endtask

    task automatic test_saturation();
        logic r;
        link_down();
        set_credits(1, 1, 1, 65530, 1, 1);
        if (err_ovf !== 1'b0) begin $display("FAIL sat_pre_ovf: got %b want 0", err_ovf); nerr++; end
        nvec++;
        crdt_up_update = 6'b000100;
        crdt_up_cnt_pd = 4'd15;
        step();
        clr_upd();
        if (err_ovf !== 1'b1) begin $display("FAIL sat_ovf: got %b want 1", err_ovf); nerr++; end
        nvec++;
        probe(2'd0, 10'd1023, r);
        if (r !== 1'b1) begin $display("FAIL sat_rdy: got %b want 1", r); nerr++; end
        nvec++;
        crdt_up_init_done = 1'b0;
        probe(2'd0, 10'd0, r);
        if (r !== 1'b0) begin $display("FAIL ld_rdy_now: got %b want 0", r); nerr++; end
        nvec++;
        step();
        probe(2'd0, 10'd0, r);
        if (r !== 1'b0) begin $display("FAIL ld_rdy_init: got %b want 0", r); nerr++; end
        nvec++;
        if (err_ovf !== 1'b1) begin $display("FAIL ld_ovf_kept: got %b want 1", err_ovf); nerr++; end
        nvec++;
        set_credits(1, 1, 1, 1, 1, 1);
        if (infinite !== 6'b000000) begin $display("FAIL reinit_inf: got %b want 000000", infinite); nerr++; end
        nvec++;
        probe(2'd0, 10'd1, r);
        if (r !== 1'b1) begin $display("FAIL reinit_pd1: got %b want 1", r); nerr++; end
        nvec++;
        probe(2'd0, 10'd2, r);
        if (r !== 1'b0) begin $display("FAIL reinit_pd2: got %b want 0", r); nerr++; end
        nvec++;
    endtask

    initial begin
        rst_n             = 1'b0;
        crdt_up_init_done = 1'b0;
        req_vld           = 1'b0;
        req_type          = 2'd0;
        req_data_crdt     = 10'd0;
        clr_upd();
        #2;
        test_reset();
        test_init();
        test_infinite();
        test_exhaustion();
        test_data_limited();
        test_simultaneous();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
